branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
// - EX-stage producer of the BTB update interface: resolves branches/jumps against the IF-stage prediction.
// - Carries btb_hit/pred_target from IF through IF/ID and ID/EX metadata registers, compares them in EX.
// - Drives cflow_valid/taken/target to the BTB and mispredict/redirect_pc to fetch and the hazard unit.
// PARAMETERS
// - ADDR_WIDTH      32  PC/target width
// - PERF_CNT_WIDTH  32  width of each perf counter (used only with PERF_COUNTERS_EN)
// PORTS
// - clk              in   1    clock, all state on posedge
// - rst_n            in   1    asynchronous active-low reset
// - btb_hit_f        in   1    IF-stage BTB hit (prediction = taken)
// - pred_target_f    in   32   IF-stage predicted target
// - stall_d/flush_d  in   1/1  hazard-unit hold/clear for IF/ID metadata
// - stall_e/flush_e  in   1/1  hazard-unit hold/clear for ID/EX metadata
// - valid_e          in   1    EX holds a real instruction (not a bubble)
// - is_branch_e      in   1    EX instruction is conditional branch
// - is_jump_e        in   1    EX instruction is JAL/JALR
// - br_cond_e        in   1    branch condition true
// - pc_e             in   32   EX instruction PC
// - actual_target_e  in   32   computed branch/jump target
// - cflow_valid      out  1    to BTB: control-flow instruction resolving this cycle
// - cflow_taken      out  1    to BTB: actual direction
// - cflow_target     out  32   to BTB: actual_target_e
// - mispredict       out  1    redirect fetch, flush younger stages
// - redirect_pc      out  32   correct next PC when mispredict=1
// - perf_cflow_cnt   out  PERF_CNT_WIDTH  resolved control-flow count
// - perf_mispred_cnt out  PERF_CNT_WIDTH  mispredict count
// BEHAVIOUR
// - Reset: IF/ID and ID/EX metadata (hit,target) = 0; perf counters = 0; all outputs 0 while rst_n=0.
// - IF/ID reg: flush_d|mispredict -> clear; else !stall_d -> capture (btb_hit_f,pred_target_f); else hold.
// - ID/EX reg: flush_e|mispredict -> clear; else !stall_e -> capture IF/ID reg; else hold. Flush beats stall.
// - resolve = valid_e & !stall_e (resolve only on the advancing cycle; stalled EX emits nothing).
// - actual_taken = is_jump_e | (is_branch_e & br_cond_e).
// - cflow_valid = resolve & (is_branch_e|is_jump_e); cflow_taken = actual_taken; cflow_target = actual_target_e.
// - mispredict (combinational, same cycle) = resolve & one of:
//   a) actual_taken & !hit_e -> redirect_pc = actual_target_e
//   b) actual_taken & hit_e & (target_e != actual_target_e) -> redirect_pc = actual_target_e
//   c) !actual_taken & hit_e (incl. non-cflow instr with stale/aliased hit) -> redirect_pc = pc_e + 4 (mod 2^32)
// - redirect_pc = 0 when mispredict=0. Mispredict clears both metadata regs on the next edge.
// - Bubble in EX (valid_e=0): no outputs asserted regardless of hit_e.
// - Async reset mid-stall/mid-flush: state clears immediately; no pending redirect survives reset.
// CONFIGURATION
// - PERF_COUNTERS_EN defined: perf_cflow_cnt += cflow_valid, perf_mispred_cnt += mispredict per cycle; wrap at 2^PERF_CNT_WIDTH.
// - PERF_COUNTERS_EN undefined: counters not built, both perf ports tied to 0; ports remain present.
// TESTING
// - Taken branch, no hit: pc_e=0x100, br_cond=1, target=0x140 -> cflow_valid=1,taken=1, mispredict=1, redirect_pc=0x140.
// - Correct prediction: hit=1,pred=0x140 carried two stages, branch taken to 0x140 -> cflow_valid=1, mispredict=0.
// - Wrong target: JALR hit pred=0x200, actual=0x300 -> mispredict=1, redirect_pc=0x300, metadata cleared next cycle.
// - Not-taken with hit: pc_e=0x1FC, hit=1, br_cond=0 -> cflow_taken=0, mispredict=1, redirect_pc=0x200; also non-cflow ALU op with hit -> mispredict, cflow_valid=0.
// - Stall/flush: stall_e=1 for 3 cycles on taken branch -> outputs 0 until release, then one cflow_valid pulse; flush_d&stall_d together -> IF/ID cleared.
// - Perf: with PERF_COUNTERS_EN, 10 branches incl. 3 mispredicts -> cflow=10, mispred=3; counter preset near max wraps to 0; without macro both read 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   EX-stage branch/jump resolution against the IF-stage BTB prediction.
//   Carries (btb_hit, pred_target) through IF/ID and ID/EX metadata registers,
//   compares in EX, and drives the BTB update and fetch redirect.
// Configuration macro: PERF_COUNTERS_EN builds the two perf counters;
//   without it both perf ports are tied to zero.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   btb_hit_f, pred_target_f        IF-stage prediction
//   stall_d/flush_d, stall_e/flush_e hazard-unit hold/clear for IF/ID, ID/EX
//   valid_e, is_branch_e, is_jump_e, br_cond_e, pc_e, actual_target_e  EX info
//   cflow_valid/taken/target        BTB update (combinational)
//   mispredict, redirect_pc         fetch redirect (combinational)
//   perf_cflow_cnt, perf_mispred_cnt performance counters
module branch_resolve_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned PERF_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      btb_hit_f,
  input  logic [ADDR_WIDTH-1:0]     pred_target_f,
  input  logic                      stall_d,
  input  logic                      flush_d,
  input  logic                      stall_e,
  input  logic                      flush_e,
  input  logic                      valid_e,
  input  logic                      is_branch_e,
  input  logic                      is_jump_e,
  input  logic                      br_cond_e,
  input  logic [ADDR_WIDTH-1:0]     pc_e,
  input  logic [ADDR_WIDTH-1:0]     actual_target_e,
  output logic                      cflow_valid,
  output logic                      cflow_taken,
  output logic [ADDR_WIDTH-1:0]     cflow_target,
  output logic                      mispredict,
  output logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic [PERF_CNT_WIDTH-1:0] perf_cflow_cnt,
  output logic [PERF_CNT_WIDTH-1:0] perf_mispred_cnt
);

  logic                  r_hit_d;
  logic [ADDR_WIDTH-1:0] r_target_d;
  logic                  r_hit_e;
  logic [ADDR_WIDTH-1:0] r_target_e;

  logic w_resolve;
  logic w_is_cflow;
  logic w_taken;
  logic w_mispredict;

  // IF/ID metadata: flush (or our own redirect) beats stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_d    <= 1'b0;
      r_target_d <= '0;
    end else if (flush_d || w_mispredict) begin
      r_hit_d    <= 1'b0;
      r_target_d <= '0;
    end else if (!stall_d) begin
      r_hit_d    <= btb_hit_f;
      r_target_d <= pred_target_f;
    end
  end

  // ID/EX metadata: flush (or our own redirect) beats stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_e    <= 1'b0;
      r_target_e <= '0;
    end else if (flush_e || w_mispredict) begin
      r_hit_e    <= 1'b0;
      r_target_e <= '0;
    end else if (!stall_e) begin
      r_hit_e    <= r_hit_d;
      r_target_e <= r_target_d;
    end
  end

  // Resolution: only on the advancing cycle of a real instruction; rst_n gates
  // the combinational outputs so nothing leaks out while reset is asserted.
  always_comb begin
    w_resolve    = rst_n & valid_e & ~stall_e;
    w_is_cflow   = is_branch_e | is_jump_e;
    w_taken      = is_jump_e | (is_branch_e & br_cond_e);
    // Non-cflow instructions with a stale hit fall into the not-taken case.
    w_mispredict = w_resolve &
                   ((w_taken & (~r_hit_e | (r_target_e != actual_target_e))) |
                    (~w_taken & r_hit_e));

    cflow_valid  = 1'b0;
    cflow_taken  = 1'b0;
    cflow_target = '0;
    mispredict   = w_mispredict;
    redirect_pc  = '0;

    if (w_resolve && w_is_cflow) begin
      cflow_valid  = 1'b1;
      cflow_taken  = w_taken;
      cflow_target = actual_target_e;
    end
    if (w_mispredict) begin
      redirect_pc = w_taken ? actual_target_e : pc_e + ADDR_WIDTH'(4);
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [PERF_CNT_WIDTH-1:0] r_perf_cflow_cnt;
  logic [PERF_CNT_WIDTH-1:0] r_perf_mispred_cnt;

  // Free-running event counters, wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cflow_cnt   <= '0;
      r_perf_mispred_cnt <= '0;
    end else begin
      r_perf_cflow_cnt   <= r_perf_cflow_cnt + PERF_CNT_WIDTH'(cflow_valid);
      r_perf_mispred_cnt <= r_perf_mispred_cnt + PERF_CNT_WIDTH'(w_mispredict);
    end
  end

  assign perf_cflow_cnt   = r_perf_cflow_cnt;
  assign perf_mispred_cnt = r_perf_mispred_cnt;
`else
  assign perf_cflow_cnt   = '0;
  assign perf_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares.
module tb_branch_resolve_unit;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;

  // {stall_d, flush_d, stall_e, flush_e}
  localparam logic [3:0] NS   = 4'b0000;
  localparam logic [3:0] S_DE = 4'b1010;
  localparam logic [3:0] FDSD = 4'b1110;
  localparam logic [3:0] FESE = 4'b1011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btb_hit_f = 1'b0;
  logic [AW-1:0] pred_target_f = '0;
  logic          stall_d = 1'b0, flush_d = 1'b0, stall_e = 1'b0, flush_e = 1'b0;
  logic          valid_e = 1'b0, is_branch_e = 1'b0, is_jump_e = 1'b0, br_cond_e = 1'b0;
  logic [AW-1:0] pc_e = '0, actual_target_e = '0;
  logic          cflow_valid, cflow_taken, mispredict;
  logic [AW-1:0] cflow_target, redirect_pc;
  logic [CW-1:0] perf_cflow_cnt, perf_mispred_cnt;

  branch_resolve_unit #(.ADDR_WIDTH(AW), .PERF_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .btb_hit_f(btb_hit_f), .pred_target_f(pred_target_f),
    .stall_d(stall_d), .flush_d(flush_d), .stall_e(stall_e), .flush_e(flush_e),
    .valid_e(valid_e), .is_branch_e(is_branch_e), .is_jump_e(is_jump_e),
    .br_cond_e(br_cond_e), .pc_e(pc_e), .actual_target_e(actual_target_e),
    .cflow_valid(cflow_valid), .cflow_taken(cflow_taken), .cflow_target(cflow_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .perf_cflow_cnt(perf_cflow_cnt), .perf_mispred_cnt(perf_mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          cv;
    logic          tk;
    logic [AW-1:0] tgt;
    logic          mp;
    logic [AW-1:0] rpc;
    logic          pchk;
    logic [CW-1:0] pcf;
    logic [CW-1:0] pmp;
  } exp_t;

  exp_t q[$];
  exp_t r;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   idx     = 0;

  logic          g_pchk = 1'b0;
  logic [CW-1:0] g_pcf  = '0;
  logic [CW-1:0] g_pmp  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s rec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // One cycle of stimulus plus its expected outputs
  task automatic step(input logic rst, input logic hf, input logic [AW-1:0] pf,
                      input logic [3:0] sfl, input logic v, input logic br,
                      input logic jp, input logic cd, input logic [AW-1:0] pc,
                      input logic [AW-1:0] tg, input logic ecv, input logic etk,
                      input logic emp, input logic [AW-1:0] erpc);
    exp_t e;
    @(posedge clk); #1;
    rst_n = ~rst;
    btb_hit_f = hf; pred_target_f = pf;
    {stall_d, flush_d, stall_e, flush_e} = sfl;
    valid_e = v; is_branch_e = br; is_jump_e = jp; br_cond_e = cd;
    pc_e = pc; actual_target_e = tg;
    e.rst = rst; e.cv = ecv; e.tk = etk; e.tgt = ecv ? tg : '0;
    e.mp = emp; e.rpc = erpc;
    e.pchk = g_pchk; e.pcf = g_pcf; e.pmp = g_pmp;
    g_pchk = 1'b0;
    q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, NS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

`ifdef PERF_COUNTERS_EN
  logic [CW-1:0] m_cf = '0;
  logic [CW-1:0] m_mp = '0;
`endif

  // Monitor: one expectation per cycle while the queue holds any
  always @(negedge clk) begin
    if (q.size() > 0) begin
      r = q.pop_front();
      idx++;
      chk("cflow_valid",  32'(cflow_valid),  32'(r.cv));
      chk("cflow_taken",  32'(cflow_taken),  32'(r.tk));
      chk("cflow_target", cflow_target,      r.tgt);
      chk("mispredict",   32'(mispredict),   32'(r.mp));
      chk("redirect_pc",  redirect_pc,       r.rpc);
`ifdef PERF_COUNTERS_EN
      if (r.rst) begin
        m_cf = '0;
        m_mp = '0;
      end
      if (r.pchk) begin
        chk("perf_cflow_hand",   32'(perf_cflow_cnt),   32'(r.pcf));
        chk("perf_mispred_hand", 32'(perf_mispred_cnt), 32'(r.pmp));
      end
      chk("perf_cflow_cnt",   32'(perf_cflow_cnt),   32'(m_cf));
      chk("perf_mispred_cnt", 32'(perf_mispred_cnt), 32'(m_mp));
      m_cf = m_cf + CW'(r.cv);
      m_mp = m_mp + CW'(r.mp);
`else
      chk("perf_cflow_cnt",   32'(perf_cflow_cnt),   32'd0);
      chk("perf_mispred_cnt", 32'(perf_mispred_cnt), 32'd0);
`endif
    end else if (cflow_valid || mispredict) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_output: got cv=%0b mp=%0b expected none", cflow_valid, mispredict);
    end
  end

  initial begin
    // Reset with a live jump in EX: every output must stay 0
    step(1, 1, 32'h55, NS, 1, 0, 1, 0, 32'h10, 32'h55, 0, 0, 0, 0);
    step(1, 0, 0, NS, 1, 1, 0, 1, 32'h10, 32'h55, 0, 0, 0, 0);
    idle();

    // Taken branch, no hit
    step(0, 0, 0, NS, 1, 1, 0, 1, 32'h100, 32'h140, 1, 1, 1, 32'h140);

    // Correct prediction carried two stages
    step(0, 1, 32'h140, NS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, NS, 1, 1, 0, 1, 32'h100, 32'h140, 1, 1, 0, 0);

    // JALR wrong target; redirect must wipe both metadata stages
    step(0, 1, 32'h200, NS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h999, NS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h777, NS, 1, 0, 1, 0, 32'h180, 32'h300, 1, 1, 1, 32'h300);
    step(0, 0, 0, NS, 1, 1, 0, 0, 32'h400, 32'h480, 1, 0, 0, 0);
    step(0, 0, 0, NS, 1, 0, 0, 0, 32'h404, 32'h0, 0, 0, 0, 0);

    // Not-taken with hit
    step(0, 1, 32'h300, NS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, NS, 1, 1, 0, 0, 32'h1FC, 32'h300, 1, 0, 1, 32'h200);

    // ALU op with aliased hit
    step(0, 1, 32'h500, NS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, NS, 1, 0, 0, 0, 32'h220, 32'h0, 0, 0, 1, 32'h224);

    // Fall-through wraps at top of address space
    step(0, 1, 32'h10, NS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, NS, 1, 1, 0, 0, 32'hFFFF_FFFC, 32'h10, 1, 0, 1, 32'h0);

    // Bubble with hit in EX: silent
    step(0, 1, 32'h600, NS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, NS, 0, 1, 0, 1, 32'h5C0, 32'h700, 0, 0, 0, 0);

    // Stall EX for 3 cycles on a correctly predicted taken branch
    step(0, 1, 32'h800, NS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, S_DE, 1, 1, 0, 1, 32'h7C0, 32'h800, 0, 0, 0, 0);
    step(0, 0, 0, NS, 1, 1, 0, 1, 32'h7C0, 32'h800, 1, 1, 0, 0);
    idle();

    // flush_d with stall_d clears IF/ID
    step(0, 1, 32'h900, NS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h900, FDSD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, NS, 1, 1, 0, 0, 32'h900, 32'h940, 1, 0, 0, 0);

    // flush_e with stall_e clears ID/EX
    step(0, 1, 32'hA40, NS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 4'b1011, 1, 1, 0, 0, 32'hA00, 32'hA40, 0, 0, 0, 0);
    step(0, 0, 0, NS, 1, 1, 0, 0, 32'hA00, 32'hA40, 1, 0, 0, 0);

    // Async reset mid-stall drops the held prediction
    step(0, 1, 32'hB00, NS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, S_DE, 1, 0, 1, 0, 32'hAF0, 32'hB00, 0, 0, 0, 0);
    step(1, 0, 0, NS, 1, 0, 1, 0, 32'hAF0, 32'hB00, 0, 0, 0, 0);
    step(0, 0, 0, NS, 1, 0, 1, 0, 32'hAF0, 32'hB00, 1, 1, 1, 32'hB00);

    // Perf: 10 branches, taken ones (1,4,7) mispredict with no hit
    step(1, 0, 0, NS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 1 || i == 4 || i == 7)
        step(0, 0, 0, NS, 1, 1, 0, 1, 32'h1000, 32'h2000, 1, 1, 1, 32'h2000);
      else
        step(0, 0, 0, NS, 1, 1, 0, 0, 32'h1000, 32'h2000, 1, 0, 0, 0);
    end
    g_pchk = 1'b1; g_pcf = 4'd10; g_pmp = 4'd3;
    idle();
    // Six more correct not-taken branches: 4-bit cflow count wraps 16 -> 0
    for (int i = 0; i < 6; i++)
      step(0, 0, 0, NS, 1, 1, 0, 0, 32'h1004, 32'h2000, 1, 0, 0, 0);
    g_pchk = 1'b1; g_pcf = 4'd0; g_pmp = 4'd3;
    idle();
    idle();

    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
